// File: rtl/nram_pkg.sv
// Shared definitions for the NRAM history bank: clog2, default sizing,
// the age-index type and the zero sample used for invalid reads.
package nram_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_AW    = clog2(DEF_DEPTH);
  localparam int unsigned DEF_CNT_W = DEF_AW + 1;

  typedef logic [DEF_AW-1:0] age_t;

  localparam logic [63:0] ZERO_SAMPLE = '0;

endpackage

// File: rtl/nram_ring_ctrl.sv
// Write pointer and fill count for the history ring: wrap at DEPTH-1,
// count saturates at DEPTH, synchronous clear beats a same-cycle push.
module nram_ring_ctrl
  import nram_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wen,
  input  logic          clr,
  output logic [AW-1:0] wr_ptr,
  output logic [AW:0]   count,
  output logic          full
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_MAX  = (AW + 1)'(DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else if (wen) begin
      wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (count != CNT_MAX) begin
        count <= count + 1'b1;
      end
      // full follows the post-push count, kept as its own flop
      full <= (count >= CNT_MAX - 1'b1);
    end
  end

endmodule

// File: rtl/nram_hist_bank.sv
// DEPTH-entry sample history with age-indexed registered read.
// Optional macro NRAM_BYPASS_EN: reads see the post-write state (io_D forwarded).
module nram_hist_bank
  import nram_pkg::*;
#(
  parameter  int unsigned W     = DEF_W,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  io_D,
  input  logic          io_WEN,
  input  logic          io_CLR,
  input  logic [AW-1:0] io_RADD,
  output logic [W-1:0]  io_Q,
  output logic          io_QV,
  output logic [AW:0]   io_COUNT,
  output logic          io_FULL
);

  localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push;

  assign push = io_WEN & ~io_CLR;

  nram_ring_ctrl #(
    .DEPTH (DEPTH)
  ) u_ring_ctrl (
    .clk    (clk),
    .reset  (reset),
    .wen    (push),
    .clr    (io_CLR),
    .wr_ptr (wr_ptr),
    .count  (count),
    .full   (full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= io_D;
    end
  end

  logic [AW:0]  radd_x;
  logic [AW:0]  ofs;
  logic [AW:0]  lim;
  logic [AW:0]  sum;
  logic [AW:0]  idx_x;
  logic         rd_valid;
  logic [W-1:0] rd_data;

  // idx = (wr_ptr - ofs - radd) mod DEPTH, biased by +DEPTH so it never goes
  // negative for a valid age; one conditional subtract finishes the modulo.
  always_comb begin
    radd_x = {1'b0, io_RADD};
`ifdef NRAM_BYPASS_EN
    ofs = push ? '0 : (AW + 1)'(1);
    lim = (push && (count != DEPTH_X)) ? count + 1'b1 : count;
`else
    ofs = (AW + 1)'(1);
    lim = count;
`endif
    rd_valid = (radd_x < lim);
    sum      = {1'b0, wr_ptr} + DEPTH_X - ofs - radd_x;
    idx_x    = (sum >= DEPTH_X) ? sum - DEPTH_X : sum;
    rd_data  = ZERO_SAMPLE[W-1:0];
    if (rd_valid) begin
      rd_data = mem[idx_x[AW-1:0]];
    end
`ifdef NRAM_BYPASS_EN
    if (push && (io_RADD == '0)) begin
      rd_data = io_D;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_Q  <= '0;
      io_QV <= 1'b0;
    end else if (io_CLR) begin
      io_Q  <= '0;
      io_QV <= 1'b0;
    end else begin
      io_Q  <= rd_data;
      io_QV <= rd_valid;
    end
  end

  assign io_COUNT = count;
  assign io_FULL  = full;

endmodule
